// File: rtl/uart_boot_loader.sv
// UART boot loader: announces 0x99, loads a length-prefixed big-endian image into imem, acks 0xAA.
// Define LOADER_CSUM_EN to require a trailing XOR checksum byte after the body.
module uart_boot_loader #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rdata,
  input  logic              rdata_ready,
  input  logic              ferr,
  output logic [7:0]        sdata,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              boot_done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_ANN,
    S_HDR,
    S_BODY,
`ifdef LOADER_CSUM_EN
    S_CSUM,
`endif
    S_ACK,
    S_DONE,
    S_ERR
  } state_t;

`ifdef LOADER_CSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_ACK;
`endif

  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  state_t          state;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_idx;
  logic            tx_guard;
  logic            ee_sent;
  logic [31:0]     full;
  logic            can_tx;
`ifdef LOADER_CSUM_EN
  logic [7:0]      csum;
`endif

  assign full = {shift, rdata};
  // tx_busy lags tx_start by a cycle, so block starts while a pulse or its shadow is in flight
  assign can_tx = !tx_busy && !tx_start && !tx_guard;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_ANN;
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
      word_cnt   <= '0;
      word_idx   <= '0;
      tx_guard   <= 1'b0;
      ee_sent    <= 1'b0;
      sdata      <= 8'd0;
      tx_start   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      boot_done  <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      tx_start <= 1'b0;
      imem_we  <= 1'b0;
      tx_guard <= tx_start;
      case (state)
        S_ANN: begin
          if (can_tx) begin
            tx_start <= 1'b1;
            sdata    <= 8'h99;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          if (rdata_ready) begin
            if (ferr) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              shift    <= full[23:0];
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (full == 32'd0) begin
                  state <= S_POST;
                end else if ({1'b0, full} > MAX_WORDS) begin
                  state <= S_ERR;
                  err   <= 1'b1;
                end else begin
                  word_cnt <= full[ADDR_W:0];
                  state    <= S_BODY;
                end
              end
            end
          end
        end
        S_BODY: begin
          if (rdata_ready) begin
            if (ferr) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              shift    <= full[23:0];
              byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CSUM_EN
              csum     <= csum ^ rdata;
`endif
              if (byte_cnt == 2'd3) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_idx[ADDR_W-1:0];
                imem_wdata <= full;
                word_idx   <= word_idx + 1'b1;
                if (word_idx + 1'b1 == word_cnt)
                  state <= S_POST;
              end
            end
          end
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          if (rdata_ready) begin
            if (ferr || rdata != csum) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state <= S_ACK;
            end
          end
        end
`endif
        S_ACK: begin
          if (can_tx) begin
            tx_start <= 1'b1;
            sdata    <= 8'hAA;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          boot_done <= 1'b1;
        end
        S_ERR: begin
          err <= 1'b1;
          if (!ee_sent && can_tx) begin
            tx_start <= 1'b1;
            sdata    <= 8'hEE;
            ee_sent  <= 1'b1;
          end
        end
        default: begin
          state <= S_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader (ADDR_W=2): vector table, event scoreboard, corner sequences.
module tb_uart_boot_loader;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    rdata = 8'd0;
  logic          rdata_ready = 1'b0;
  logic          ferr = 1'b0;
  logic [7:0]    sdata;
  logic          tx_start;
  logic          tx_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          boot_done;
  logic          err;

  int checks = 0;
  int errors = 0;

  uart_boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rdata(rdata), .rdata_ready(rdata_ready), .ferr(ferr),
    .sdata(sdata), .tx_start(tx_start), .tx_busy(tx_busy), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .boot_done(boot_done), .err(err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after tx_start and lasts a dozen cycles
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (!rstn) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 12;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  typedef struct {
    logic          is_tx;
    logic [7:0]    tx;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [31:0]       count;
    int                nwords;
    logic [3:0][31:0]  words;
    int                ferr_at;
    logic [7:0]        csum_flip;
    logic              exp_done;
    logic              exp_err;
  } vec_t;

  function automatic ev_t txEv(input logic [7:0] b);
    ev_t e;
    e.is_tx = 1'b1; e.tx = b; e.addr = '0; e.data = 32'd0;
    return e;
  endfunction

  function automatic ev_t wrEv(input int a, input logic [31:0] d);
    ev_t e;
    e.is_tx = 1'b0; e.tx = 8'd0; e.addr = AW'(a); e.data = d;
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] count, input int nw, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                              input int fat, input logic [7:0] flip, input logic d, input logic e);
    vec_t v;
    v.count = count; v.nwords = nw; v.words = {w3, w2, w1, w0};
    v.ferr_at = fat; v.csum_flip = flip; v.exp_done = d; v.exp_err = e;
    return v;
  endfunction

  // Monitor: every tx_start or imem_we is popped against the scoreboard
  ev_t  mon_ev;
  logic prev_aa = 1'b0;
  logic prev_done = 1'b0;
  int   tx_seen = 0;
  always @(negedge clk) begin
    if (tx_start) begin
      tx_seen++;
      checks++;
      if (tx_busy) begin errors++; $display("[TB] FAIL tx_while_busy: tx_busy=%b required 0", tx_busy); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("[TB] FAIL unexpected_tx: got sdata=%h required no transmit", sdata);
      end else begin
        mon_ev = exp_q.pop_front();
        if (!mon_ev.is_tx || mon_ev.tx != sdata) begin
          errors++;
          $display("[TB] FAIL tx_byte: got tx %h required is_tx=%b tx=%h", sdata, mon_ev.is_tx, mon_ev.tx);
        end
      end
      if (sdata == 8'hAA) begin
        checks++;
        if (imem_we) begin errors++; $display("[TB] FAIL aa_after_we: imem_we=%b required 0", imem_we); end
      end
    end
    if (imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("[TB] FAIL unexpected_write: got addr=%0d data=%h required none", imem_addr, imem_wdata);
      end else begin
        mon_ev = exp_q.pop_front();
        if (mon_ev.is_tx || mon_ev.addr != imem_addr || mon_ev.data != imem_wdata) begin
          errors++;
          $display("[TB] FAIL write: got addr=%0d data=%h required is_tx=%b addr=%0d data=%h",
                   imem_addr, imem_wdata, mon_ev.is_tx, mon_ev.addr, mon_ev.data);
        end
      end
    end
    if (boot_done && !prev_done) begin
      checks++;
      if (!prev_aa) begin errors++; $display("[TB] FAIL done_timing: prev cycle AA start=%b required 1", prev_aa); end
    end
    prev_aa   = tx_start && (sdata == 8'hAA);
    prev_done = boot_done;
  end

  task automatic sendByte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rdata = b; ferr = fe; rdata_ready = 1'b1;
    @(negedge clk);
    rdata_ready = 1'b0; ferr = 1'b0;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sdata, tx_start, imem_we, imem_addr, imem_wdata, boot_done, err} != '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got sdata=%h start=%b we=%b addr=%0d wdata=%h done=%b err=%b required all 0",
               sdata, tx_start, imem_we, imem_addr, imem_wdata, boot_done, err);
    end
    exp_q.delete();
    exp_q.push_back(txEv(8'h99));
    rstn = 1'b1;
    if (!force_busy) begin
      @(negedge clk);
      checks++;
      if (!(tx_start && sdata == 8'h99)) begin
        errors++; $display("[TB] FAIL ann_timing: got start=%b sdata=%h required 1/99", tx_start, sdata);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] word;
    logic        fe;
    logic        dead;
    logic        bad_count;
    int          idx;
    int          n;
    cs = 8'd0; idx = 0; dead = 1'b0;
    bad_count = (v.count > 32'd4);
    doReset();
    for (int k = 0; k < 4; k++) begin
      b  = 8'(v.count >> (24 - 8 * k));
      fe = (idx == v.ferr_at);
      if (fe || (k == 3 && bad_count)) exp_q.push_back(txEv(8'hEE));
      sendByte(b, fe);
      idx++;
      if (fe || (k == 3 && bad_count)) begin
        checks++;
        if (!err) begin errors++; $display("[TB] FAIL err_timing_hdr: err=%b required 1", err); end
        dead = 1'b1;
        break;
      end
    end
    if (!dead) begin
      for (int w = 0; w < v.nwords; w++) begin
        word = v.words[w];
        for (int bt = 0; bt < 4; bt++) begin
          b  = 8'(word >> (24 - 8 * bt));
          fe = (idx == v.ferr_at);
          if (fe) exp_q.push_back(txEv(8'hEE));
          else if (bt == 3) exp_q.push_back(wrEv(w, word));
          sendByte(b, fe);
          idx++;
          if (fe) begin
            checks++;
            if (!err) begin errors++; $display("[TB] FAIL err_timing_body: err=%b required 1", err); end
            dead = 1'b1;
            break;
          end
          cs = cs ^ b;
          if (bt == 3) begin
            checks++;
            if (!imem_we) begin errors++; $display("[TB] FAIL we_timing: imem_we=%b required 1", imem_we); end
          end
        end
        if (dead) break;
      end
    end
    if (!dead) begin
`ifdef LOADER_CSUM_EN
      exp_q.push_back(txEv((v.csum_flip == 8'd0) ? 8'hAA : 8'hEE));
      sendByte(cs ^ v.csum_flip, 1'b0);
`else
      exp_q.push_back(txEv(8'hAA));
`endif
    end
    n = 0;
    while (!(boot_done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("[TB] FAIL timeout: done=%b err=%b required one of them within 200 cycles", boot_done, err);
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic exp_done, input logic exp_err);
    checks++;
    if (boot_done != exp_done) begin
      errors++; $display("[TB] FAIL %s boot_done: got %b required %b", name, boot_done, exp_done);
    end
    checks++;
    if (err != exp_err) begin
      errors++; $display("[TB] FAIL %s err: got %b required %b", name, err, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("[TB] FAIL %s pending_events: got %0d left required 0", name, exp_q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

`ifdef LOADER_CSUM_EN
  localparam int NV = 9;
`else
  localparam int NV = 8;
`endif

  initial begin
    vec_t vecs[9];
    int   n0;
    vecs[0] = mk(32'd2, 2, 32'hDEADBEEF, 32'h01020304, 32'd0, 32'd0, -1, 8'h00, 1'b1, 1'b0);
    vecs[1] = mk(32'd0, 0, 32'd0, 32'd0, 32'd0, 32'd0, -1, 8'h00, 1'b1, 1'b0);
    vecs[2] = mk(32'd5, 0, 32'd0, 32'd0, 32'd0, 32'd0, -1, 8'h00, 1'b0, 1'b1);
    vecs[3] = mk(32'h00010000, 0, 32'd0, 32'd0, 32'd0, 32'd0, -1, 8'h00, 1'b0, 1'b1);
    vecs[4] = mk(32'd2, 2, 32'hDEADBEEF, 32'h01020304, 32'd0, 32'd0, 6, 8'h00, 1'b0, 1'b1);
    vecs[5] = mk(32'd4, 4, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, -1, 8'h00, 1'b1, 1'b0);
    vecs[6] = mk(32'd3, 3, 32'h1, 32'h2, 32'h3, 32'd0, 1, 8'h00, 1'b0, 1'b1);
    vecs[7] = mk(32'd1, 1, 32'h11223344, 32'd0, 32'd0, 32'd0, -1, 8'h00, 1'b1, 1'b0);
    vecs[8] = mk(32'd1, 1, 32'h11223344, 32'd0, 32'd0, 32'd0, -1, 8'h01, 1'b0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_err);
    end

    // Announce must wait for an idle transmitter
    force_busy = 1'b1;
    doReset();
    n0 = tx_seen;
    repeat (10) @(negedge clk);
    checks++;
    if (tx_seen != n0) begin errors++; $display("[TB] FAIL ann_wait_busy: got %0d starts required 0", tx_seen - n0); end
    force_busy = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_seen != n0 + 1) begin errors++; $display("[TB] FAIL ann_after_busy: got %0d starts required 1", tx_seen - n0); end
    checkOutput("busy_ann", 1'b0, 1'b0);

    // Reset mid-image, then a full image must load from address 0
    doReset();
    sendByte(8'h00, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h00, 1'b0); sendByte(8'h02, 1'b0);
    sendByte(8'hDE, 1'b0); sendByte(8'hAD, 1'b0);
    applyStimulus(vecs[0]);
    checkOutput("restart", 1'b1, 1'b0);

    // Strobes after completion are ignored, including framing errors
    for (int k = 0; k < 4; k++) sendByte(8'h55, 1'b0);
    sendByte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("post_done", 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Device-side boot loader at the CPU end of the UART download link. After reset it announces readiness with byte 0x99, receives a length-prefixed program image, writes it word by word into instruction memory, acknowledges with 0xAA, then releases the core and hands the UART receive path to it for the data phase. It sits in `top` between `uart_rx`/`uart_tx` and the instruction-memory write port.

## Interface
- `ADDR_W`, 14: instruction-memory word-address width; capacity 2^ADDR_W words.
- `clk`  in  1  clock.
- `rstn`  in  1  reset; synchronous, active-low.
- `rdata`  in  8  byte from `uart_rx`.
- `rdata_ready`  in  1  one-cycle strobe; `rdata` valid.
- `ferr`  in  1  framing error, qualified by `rdata_ready`.
- `sdata`  out  8  byte to `uart_tx`.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_busy`  in  1  transmitter busy.
- `imem_we`  out  1  instruction-memory write enable, one cycle per word.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  word data.
- `boot_done`  out  1  level; core may run; rx ownership passes to core.
- `err`  out  1  level; sticky boot error.

## Operation
- Wire format: 4-byte word count W, big-endian; then 4·W bytes, each word big-endian (first byte = bits 31:24).
- States:
  - S_ANN: when `tx_busy`=0 and guard clear, pulse `tx_start` with `sdata`=0x99; go to S_HDR.
  - S_HDR: collect 4 count bytes. After the 4th byte: W=0 → S_ACK; W > 2^ADDR_W → S_ERR; else → S_BODY.
  - S_BODY: shift bytes into a 32-bit assembler. On each 4th byte, write the word at the current index, then increment the index. After word W−1 → S_ACK, or S_CSUM if the macro is defined.
  - S_ACK: when `tx_busy`=0 and guard clear, pulse `tx_start` with 0xAA; go to S_DONE.
  - S_DONE: `boot_done`=1; ignore all rx strobes; terminal until reset.
  - S_ERR: `err`=1; send 0xEE once using the same tx rules; terminal until reset.
- Transmit guard: after any `tx_start`, suppress further starts for one cycle, because `tx_busy` rises one cycle late.
- `rdata_ready` with `ferr`=1 in S_HDR, S_BODY or S_CSUM → S_ERR. The faulty byte is discarded.
- Rx strobes in S_ANN are ignored. Bytes arriving after the 0x99 request but before the transmit completes are accepted.
- Word index counter is ADDR_W+1 bits wide, so W = 2^ADDR_W is legal with no wrap.

## Timing
- Reset values: `sdata`=0, `tx_start`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `boot_done`=0, `err`=0. State = S_ANN.
- First `tx_start` (0x99) occurs in the 1st cycle after `rstn` deasserts, provided `tx_busy`=0.
- `imem_we`, `imem_addr`, `imem_wdata` are registered. They are valid in the cycle after the `rdata_ready` of the word's 4th byte.
- 0xAA `tx_start` occurs no earlier than 1 cycle after the last `imem_we`, and is additionally gated by `tx_busy`.
- `boot_done` rises in the cycle after the 0xAA `tx_start` pulse.
- `err` rises in the cycle after the offending strobe or count.
- `rstn` low at any point: all outputs return to reset values on the next edge and the sequence restarts with 0x99. A partial image is not resumed.

## Configuration
- `LOADER_CSUM_EN` defined:
  - S_CSUM receives one byte after the body, expected to equal the XOR of all 4·W body bytes; the count bytes are excluded.
  - For W=0 the checksum byte is still received and must be 0x00.
  - Match → S_ACK. Mismatch → S_ERR (sends 0xEE; `boot_done` never rises).
- `LOADER_CSUM_EN` undefined: no checksum byte is expected and S_CSUM is absent.

## Test plan
- Reset, `tx_busy`=0 → exactly one `tx_start` with 0x99; no second start while `tx_busy` is high.
- Send 00 00 00 02, DE AD BE EF, 01 02 03 04 → writes (0, 0xDEADBEEF) and (1, 0x01020304); then 0xAA `tx_start`; `boot_done`=1 next cycle.
- Send 00 00 00 00 (checksum 00 when enabled) → no `imem_we`; 0xAA sent; `boot_done`=1.
- With ADDR_W=2, send count 00 00 00 05 → `err`=1, 0xEE sent, no writes.
- `ferr`=1 on 3rd body byte → `err`=1, 0xEE sent, no write for that word. Then pulse `rstn` → 0x99 re-sent, and a full clean image loads from address 0.
- `LOADER_CSUM_EN`, body 11 22 33 44: checksum 0x44 → 0xAA sent; checksum 0x45 → 0xEE sent, `boot_done` stays 0.
